// File: rtl/ram_loader.sv
// Byte-stream to AXI-Lite write sequencer: packs bytes little-endian into
// words and writes them one at a time from BASE_ADDR upward.
module ram_loader #(
  parameter int                    DATA_WIDTH = 32,
  parameter int                    ADDR_WIDTH = 16,
  parameter int                    STRB_WIDTH = DATA_WIDTH/8,
  parameter logic [ADDR_WIDTH-1:0] BASE_ADDR  = '0,
  parameter int                    LOAD_BYTES = 1024
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic [7:0]            s_data,
  input  logic                  s_valid,
  output logic                  s_ready,
  output logic [ADDR_WIDTH-1:0] awaddr,
  output logic [2:0]            awprot,
  output logic                  awvalid,
  input  logic                  awready,
  output logic [DATA_WIDTH-1:0] wdata,
  output logic [STRB_WIDTH-1:0] wstrb,
  output logic                  wvalid,
  input  logic                  wready,
  input  logic [1:0]            bresp,
  input  logic                  bvalid,
  output logic                  bready,
  output logic                  busy,
  output logic                  done,
  output logic                  error
);
  localparam int CW = (LOAD_BYTES > 0) ? $clog2(LOAD_BYTES + 1) : 1;
  localparam int LW = (STRB_WIDTH > 1) ? $clog2(STRB_WIDTH) : 1;
  localparam logic [CW-1:0] LOAD_N    = CW'(LOAD_BYTES);
  localparam logic [LW-1:0] LAST_LANE = LW'(STRB_WIDTH - 1);

  typedef enum logic [2:0] {IDLE, COLLECT, WRITE, RESP, DONE} state_t;

  state_t        state;
  logic [CW-1:0] count;
  logic [LW-1:0] lane;
  logic          aw_ok;
  logic          w_ok;

  assign awprot  = 3'b000;
  assign s_ready = (state == COLLECT);
  assign bready  = (state == RESP);
  assign busy    = (state != IDLE) && (state != DONE);
  assign done    = (state == DONE);
  // A channel is finished once its valid is low or its handshake completes now.
  assign aw_ok   = !awvalid || awready;
  assign w_ok    = !wvalid || wready;

  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= IDLE;
      awvalid <= 1'b0;
      wvalid  <= 1'b0;
      error   <= 1'b0;
      awaddr  <= BASE_ADDR;
      wdata   <= '0;
      wstrb   <= '0;
      count   <= '0;
      lane    <= '0;
    end else begin
      case (state)
        IDLE, DONE: begin
          if (start) begin
            error  <= 1'b0;
            count  <= '0;
            lane   <= '0;
            wdata  <= '0;
            wstrb  <= '0;
            awaddr <= BASE_ADDR;
            state  <= (LOAD_BYTES == 0) ? DONE : COLLECT;
          end
        end
        COLLECT: begin
          if (s_valid) begin
            wdata[8*int'(lane) +: 8] <= s_data;
            wstrb[lane]              <= 1'b1;
            lane                     <= lane + LW'(1);
            count                    <= count + CW'(1);
            if (lane == LAST_LANE || count + CW'(1) == LOAD_N) begin
              state   <= WRITE;
              awvalid <= 1'b1;
              wvalid  <= 1'b1;
            end
          end
        end
        WRITE: begin
          if (awready) awvalid <= 1'b0;
          if (wready)  wvalid  <= 1'b0;
          if (aw_ok && w_ok) state <= RESP;
        end
        RESP: begin
          if (bvalid) begin
            error  <= error | (bresp != 2'b00);
            awaddr <= awaddr + ADDR_WIDTH'(STRB_WIDTH);
            wdata  <= '0;
            wstrb  <= '0;
            lane   <= '0;
            state  <= (count == LOAD_N) ? DONE : COLLECT;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_ram_loader.sv
// Randomized bench for ram_loader: AXI-Lite slave and byte source models,
// expected writes rebuilt from the accepted byte stream.
module tb_ram_loader;
  localparam int          SW   = 4;
  localparam int          LB   = 14;
  localparam logic [15:0] BASE = 16'hFFF8;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start = 1'b0;
  logic [7:0]  s_data = '0;
  logic        s_valid = 1'b0;
  logic        awready = 1'b0, wready = 1'b0, bvalid = 1'b0;
  logic [1:0]  bresp = 2'b00;
  logic        s_ready, awvalid, wvalid, bready, busy, done, error;
  logic [15:0] awaddr;
  logic [2:0]  awprot;
  logic [31:0] wdata;
  logic [3:0]  wstrb;

  logic        s_ready0, awvalid0, wvalid0, bready0, busy0, done0, error0;
  logic [15:0] awaddr0;
  logic [2:0]  awprot0;
  logic [31:0] wdata0;
  logic [3:0]  wstrb0;

  int unsigned n_chk = 0, n_err = 0;
  int unsigned mode = 0;            // 0 zero-wait, 1 random waits, 2 stall
  bit          force_err = 1'b0;
  bit          exp_err = 1'b0;
  bit          aw0_ever = 1'b0;
  int unsigned nb = 0, nresp = 0;
  logic [7:0]  rx[$];
  logic [15:0] awq[$];
  logic [31:0] wdq[$];
  logic [3:0]  wsq[$];

  always #5 clk = ~clk;

  ram_loader #(.DATA_WIDTH(32), .ADDR_WIDTH(16), .BASE_ADDR(BASE), .LOAD_BYTES(LB)) dut (
    .clk(clk), .rst(rst), .start(start), .s_data(s_data), .s_valid(s_valid), .s_ready(s_ready),
    .awaddr(awaddr), .awprot(awprot), .awvalid(awvalid), .awready(awready),
    .wdata(wdata), .wstrb(wstrb), .wvalid(wvalid), .wready(wready),
    .bresp(bresp), .bvalid(bvalid), .bready(bready), .busy(busy), .done(done), .error(error));

  ram_loader #(.DATA_WIDTH(32), .ADDR_WIDTH(16), .BASE_ADDR(16'h0000), .LOAD_BYTES(0)) dut0 (
    .clk(clk), .rst(rst), .start(start), .s_data(8'h00), .s_valid(1'b0), .s_ready(s_ready0),
    .awaddr(awaddr0), .awprot(awprot0), .awvalid(awvalid0), .awready(1'b0),
    .wdata(wdata0), .wstrb(wstrb0), .wvalid(wvalid0), .wready(1'b0),
    .bresp(2'b00), .bvalid(1'b0), .bready(bready0), .busy(busy0), .done(done0), .error(error0));

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Byte source and AXI-Lite slave: drive at negedge, sample handshakes 1ns later.
  initial begin
    bit          aw_got = 0, w_got = 0, b_taken = 0;
    bit          p_aw_pend = 0, p_w_pend = 0, p_aw_hs = 0, p_w_hs = 0;
    logic [15:0] p_awaddr = '0;
    logic [31:0] p_wdata = '0;
    logic [3:0]  p_wstrb = '0;
    logic [1:0]  cur_resp = 2'b00;
    forever begin
      @(negedge clk);
      if (b_taken) begin bvalid = 1'b0; b_taken = 0; end
      if (mode == 2) begin awready = 1'b0; wready = 1'b0; end
      else if (mode == 0) begin awready = 1'b1; wready = 1'b1; end
      else begin
        awready = ($urandom_range(0, 2) == 0);
        wready  = ($urandom_range(0, 2) == 0);
      end
      if (!bvalid) bvalid = aw_got && w_got && (mode == 0 || $urandom_range(0, 1) == 1);
      bresp   = bvalid ? cur_resp : 2'b00;
      s_valid = (mode == 0) || ($urandom_range(0, 1) == 1);
      s_data  = 8'($urandom_range(0, 255));
      #1;
      if (awvalid0 || wvalid0) aw0_ever = 1'b1;
      if (rst) begin
        aw_got = 0; w_got = 0; b_taken = 0; bvalid = 1'b0;
        p_aw_pend = 0; p_w_pend = 0; p_aw_hs = 0; p_w_hs = 0;
        rx.delete(); awq.delete(); wdq.delete(); wsq.delete();
        nb = 0; nresp = 0; exp_err = 0;
      end else begin
        if (p_aw_pend) begin check_eq("aw_hold", awvalid, 1); check_eq("aw_stable", awaddr, p_awaddr); end
        if (p_w_pend) begin
          check_eq("w_hold", wvalid, 1);
          check_eq("wdata_stable", wdata, p_wdata);
          check_eq("wstrb_stable", wstrb, p_wstrb);
        end
        if (p_aw_hs) check_eq("aw_drop", awvalid, 0);
        if (p_w_hs)  check_eq("w_drop", wvalid, 0);
        if (awvalid || wvalid) check_eq("s_ready_in_write", s_ready, 0);
        if (s_valid && s_ready) rx.push_back(s_data);
        p_aw_hs = awvalid && awready;
        p_w_hs  = wvalid && wready;
        p_aw_pend = awvalid && !awready;
        p_w_pend  = wvalid && !wready;
        p_awaddr = awaddr; p_wdata = wdata; p_wstrb = wstrb;
        if (p_aw_hs) begin
          check_eq("one_outstanding_aw", aw_got, 0);
          awq.push_back(awaddr);
          aw_got = 1;
        end
        if (p_w_hs) begin
          check_eq("one_outstanding_w", w_got, 0);
          wdq.push_back(wdata);
          wsq.push_back(wstrb);
          w_got = 1;
          if (force_err && nresp == 0) cur_resp = 2'b10;
          else if (mode == 1 && $urandom_range(0, 3) == 0) cur_resp = 2'b10;
          else cur_resp = 2'b00;
          nresp++;
          if (cur_resp != 2'b00) exp_err = 1'b1;
        end
        if (bvalid && bready) begin
          aw_got = 0; w_got = 0; b_taken = 1; nb++;
        end
      end
    end
  end

  task automatic do_start();
    rx.delete(); awq.delete(); wdq.delete(); wsq.delete();
    nb = 0; nresp = 0; exp_err = 1'b0;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    check_eq("start_err_clear", error, 0);
    check_eq("start_addr", awaddr, BASE);
    check_eq("start_busy", busy, 1);
    check_eq("zero_len_done", done0, 1);
    check_eq("zero_len_busy", busy0, 0);
  endtask

  task automatic wait_done(output int unsigned cyc);
    cyc = 0;
    while (!done && cyc < 2000) begin
      @(negedge clk);
      cyc++;
    end
    check_eq("done_reached", done, 1);
    check_eq("done_not_busy", busy, 0);
  endtask

  task automatic check_load();
    int unsigned nw;
    logic [31:0] ed;
    logic [3:0]  es;
    logic [15:0] ea;
    int unsigned j;
    nw = (LB + SW - 1) / SW;
    check_eq("byte_count", rx.size(), LB);
    check_eq("aw_count", awq.size(), nw);
    check_eq("w_count", wdq.size(), nw);
    check_eq("b_count", nb, nw);
    for (int unsigned i = 0; i < nw; i++) begin
      ed = '0; es = '0;
      for (int unsigned k = 0; k < SW; k++) begin
        j = i * SW + k;
        if (j < LB && j < rx.size()) begin
          ed = ed | (32'(rx[j]) << (8 * k));
          es[k] = 1'b1;
        end
      end
      ea = BASE + 16'(i * SW);
      if (i < awq.size()) check_eq("awaddr", awq[i], ea);
      if (i < wdq.size()) begin
        check_eq("wdata", wdq[i], ed);
        check_eq("wstrb", wsq[i], es);
      end
    end
    check_eq("error_flag", error, exp_err);
  endtask

  initial begin
    int unsigned cyc;
    repeat (3) @(negedge clk);
    check_eq("rst_s_ready", s_ready, 0);
    check_eq("rst_awvalid", awvalid, 0);
    check_eq("rst_wvalid", wvalid, 0);
    check_eq("rst_bready", bready, 0);
    check_eq("rst_busy", busy, 0);
    check_eq("rst_done", done, 0);
    check_eq("rst_error", error, 0);
    check_eq("rst_awaddr", awaddr, BASE);
    check_eq("rst_wdata", wdata, 0);
    check_eq("rst_wstrb", wstrb, 0);
    check_eq("rst_awprot", awprot, 0);
    check_eq("rst_done0", done0, 0);
    rst = 1'b0;
    @(negedge clk);

    // zero-wait load: 14 byte cycles plus WRITE and RESP for each of 4 words
    mode = 0;
    do_start();
    wait_done(cyc);
    check_eq("zero_wait_cycles", cyc, 22);
    check_load();

    // random waits, first response forced to SLVERR
    mode = 1; force_err = 1'b1;
    do_start();
    wait_done(cyc);
    check_load();
    check_eq("forced_error", error, 1);
    force_err = 1'b0;

    for (int unsigned n = 0; n < 4; n++) begin
      do_start();
      wait_done(cyc);
      check_load();
    end

    // reset while WRITE is stalled
    mode = 2;
    do_start();
    cyc = 0;
    while (!awvalid && cyc < 500) begin
      @(negedge clk);
      cyc++;
    end
    check_eq("stall_awvalid", awvalid, 1);
    check_eq("stall_s_ready", s_ready, 0);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check_eq("abort_awvalid", awvalid, 0);
    check_eq("abort_wvalid", wvalid, 0);
    check_eq("abort_bready", bready, 0);
    check_eq("abort_s_ready", s_ready, 0);
    check_eq("abort_busy", busy, 0);
    check_eq("abort_done", done, 0);

    mode = 0;
    @(negedge clk);
    do_start();
    wait_done(cyc);
    check_load();
    check_eq("zero_len_no_aw", aw0_ever, 0);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end
endmodule

// File: doc/ram_loader.md
Name: ram_loader

Overview:
- AXI-Lite write-master sequencer that fills the byte-addressed RAM from a byte stream, e.g. a UART boot image.
- Packs incoming bytes little-endian into DATA_WIDTH words and issues one AXI-Lite write per word from BASE_ADDR upward.
- Reports completion and any slave error.
- Sits between the byte source and the RAM write channels (aw/w/b); the read channels are untouched.

Parameters:
- DATA_WIDTH, 32: AXI data width in bits.
- ADDR_WIDTH, 16: AXI byte-address width.
- STRB_WIDTH, DATA_WIDTH/8: byte lanes per word.
- BASE_ADDR, 0: first byte address written; must be STRB_WIDTH-aligned.
- LOAD_BYTES, 1024: bytes loaded per start; 0 is legal.

Ports:
- clk  input  1  clock, all logic on rising edge.
- rst  input  1  reset, synchronous, active-high.
- start  input  1  one-cycle load request, honoured only in IDLE or DONE.
- s_data  input  8  stream byte.
- s_valid  input  1  stream byte valid.
- s_ready  output  1  stream byte accepted when s_valid&&s_ready.
- awaddr  output  ADDR_WIDTH  write address.
- awprot  output  3  tied 3'b000.
- awvalid  output  1  address valid.
- awready  input  1  address ready.
- wdata  output  DATA_WIDTH  write data.
- wstrb  output  STRB_WIDTH  byte enables.
- wvalid  output  1  data valid.
- wready  input  1  data ready.
- bresp  input  2  write response.
- bvalid  input  1  response valid.
- bready  output  1  response ready.
- busy  output  1  state not IDLE and not DONE.
- done  output  1  held high in DONE.
- error  output  1  sticky: some bresp != 0 this load.

Behaviour:
- Reset: state=IDLE on the clk edge with rst=1. s_ready, awvalid, wvalid, bready, busy, done, error all 0. awaddr=BASE_ADDR, wdata=0, wstrb=0.
- Reset mid-operation: aborts the load, discards the partial word, drops all valids the following cycle. No AXI handshake completes on a cycle with rst=1.
- States: IDLE, COLLECT, WRITE, RESP, DONE.
- Start handling:
  - IDLE/DONE + start: clear error, byte count, lane index and strobe; addr=BASE_ADDR.
  - Go to COLLECT, or directly to DONE if LOAD_BYTES==0 (no AXI traffic).
  - start in any other state is ignored.
- COLLECT:
  - s_ready=1, combinational on state only.
  - Accepted byte goes to lane k, bits [8k+7:8k]; strb[k] set; k increments; byte count increments.
  - Go to WRITE when lane STRB_WIDTH-1 is filled or count reaches LOAD_BYTES.
  - Unfilled lanes carry data 0, strobe 0.
- WRITE:
  - awvalid and wvalid both assert on the entry cycle.
  - Each drops the cycle after its own handshake; aw and w may complete in either order or the same cycle.
  - awaddr/wdata/wstrb stay stable while the respective valid is high.
  - s_ready=0.
  - Go to RESP once both handshakes have completed.
- RESP:
  - bready=1.
  - On bvalid: error |= (bresp!=0); addr += STRB_WIDTH, modulo 2^ADDR_WIDTH (wraps); clear lanes/strobe.
  - Go to DONE if count==LOAD_BYTES, else COLLECT.
- Latency: a full word costs at most 3 cycles after its last byte with a zero-wait slave (WRITE, RESP, back to COLLECT).
- Write ordering: exactly one write outstanding at any time.
- Error handling: a slave error does not stop the load.
- Byte counter width: $clog2(LOAD_BYTES+1).
- DONE: done=1, busy=0; start restarts the load.

Test Plan:
- LOAD_BYTES=8, start, stream 01..08, zero-wait slave -> writes (0x0000, 0x04030201, 0xF) then (0x0004, 0x08070605, 0xF); done=1, error=0, exactly 8 s_ready handshakes.
- LOAD_BYTES=6, bytes 01..06 -> second write is awaddr 0x0004, wdata 0x00000605, wstrb 0x3; then done.
- awready held low 3 cycles, wready immediate -> wvalid drops after 1 cycle; awvalid stays high with awaddr stable until its handshake; one write total; s_ready=0 throughout.
- First bresp=2'b10, second 2'b00 -> error=1 at done, both writes issued; a new start clears error to 0 and reloads from BASE_ADDR.
- BASE_ADDR=0xFFFC, LOAD_BYTES=8 -> awaddr 0xFFFC then 0x0000 (wrap).
- rst pulsed while in WRITE -> next cycle awvalid=wvalid=bready=s_ready=busy=0; LOAD_BYTES=0 with start -> done=1 next cycle, no awvalid ever.
